// File: rtl/feature_map_pingpong_buffer.sv
// Ping-pong feature-map buffer: the loader fills one bank with narrow words while the
// PE array drains the other bank as wide words. Banks swap on tile-level handshakes.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// BANK_FREE | bank may be filled by the loader; not visible to the reader
// BANK_FULL | tile committed by wr_last; readable until released by rd_last
module feature_map_pingpong_buffer #(
    parameter int LANES         = 9,
    parameter int LANE_WR_WIDTH = 36,
    parameter int RATIO         = 4,
    parameter int WR_ADDR_DEPTH = 10,
    localparam int SLOT_BITS     = $clog2(RATIO),
    localparam int RD_ADDR_DEPTH = WR_ADDR_DEPTH - SLOT_BITS
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [LANES*LANE_WR_WIDTH-1:0]         wr_data,
    input  logic                                   wr_valid,
    input  logic [WR_ADDR_DEPTH-1:0]               wr_addr,
    input  logic                                   wr_last,
    output logic                                   wr_ready,
    input  logic                                   rd_req,
    input  logic [RD_ADDR_DEPTH-1:0]               rd_addr,
    input  logic                                   rd_last,
    output logic                                   rd_bank_ready,
    output logic [LANES*LANE_WR_WIDTH*RATIO-1:0]   rd_data,
    output logic                                   rd_valid,
    output logic                                   wr_bank,
    output logic                                   rd_bank,
    output logic [1:0]                             full_count,
    output logic                                   wr_err,
    output logic                                   rd_err
);

    localparam int LANE_RD_W = LANE_WR_WIDTH * RATIO;
    localparam int RD_W      = LANES * LANE_RD_W;
    localparam int SLOT_W    = (SLOT_BITS > 0) ? SLOT_BITS : 1;
    localparam int ROWS      = 2 ** (RD_ADDR_DEPTH + 1);

    typedef enum logic {
        BANK_FREE = 1'b0,
        BANK_FULL = 1'b1
    } bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];

    // Both banks share one array; the bank select is the row MSB.
    logic [RD_W-1:0] mem [ROWS];

    logic [SLOT_W-1:0]        wr_slot;
    logic [RD_ADDR_DEPTH-1:0] wr_row;
    logic                     wr_acc;
    logic                     wr_commit;
    logic                     rd_acc;
    logic                     rd_release;

    generate
        if (SLOT_BITS == 0) begin : g_no_slot
            assign wr_slot = '0;
            assign wr_row  = wr_addr;
        end else begin : g_slot
            assign wr_slot = wr_addr[SLOT_BITS-1:0];
            assign wr_row  = wr_addr[WR_ADDR_DEPTH-1:SLOT_BITS];
        end
    endgenerate

    assign wr_ready      = (bank_q[wr_bank] == BANK_FREE);
    assign rd_bank_ready = (bank_q[rd_bank] == BANK_FULL);
    assign full_count    = 2'(bank_q[0] == BANK_FULL) + 2'(bank_q[1] == BANK_FULL);

    assign wr_acc     = wr_valid & wr_ready & ~rst;
    assign wr_commit  = wr_acc & wr_last;
    assign rd_acc     = rd_req & rd_bank_ready & ~rst;
    assign rd_release = rd_acc & rd_last;

    // Commit and release always target different banks (FREE vs FULL), so both may apply.
    always_comb begin
        bank_d[0] = bank_q[0];
        bank_d[1] = bank_q[1];
        if (wr_commit) begin
            bank_d[wr_bank] = BANK_FULL;
        end
        if (rd_release) begin
            bank_d[rd_bank] = BANK_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q[0] <= BANK_FREE;
            bank_q[1] <= BANK_FREE;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_err    <= 1'b0;
            rd_err    <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            bank_q[0] <= bank_d[0];
            bank_q[1] <= bank_d[1];
            if (wr_commit) begin
                wr_bank <= ~wr_bank;
            end
            if (rd_release) begin
                rd_bank <= ~rd_bank;
            end
            if (wr_valid && !wr_ready) begin
                wr_err <= 1'b1;
            end
            if (rd_req && !rd_bank_ready) begin
                rd_err <= 1'b1;
            end
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[{rd_bank, rd_addr}];
            end
        end
    end

    // Sub-word masked write: each lane's narrow word lands in its slot of the wide row.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int i = 0; i < LANES; i++) begin
                mem[{wr_bank, wr_row}][i*LANE_RD_W + int'(wr_slot)*LANE_WR_WIDTH +: LANE_WR_WIDTH]
                    <= wr_data[i*LANE_WR_WIDTH +: LANE_WR_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_feature_map_pingpong_buffer.sv
// Bench for the ping-pong buffer: three instances (RATIO 4, 2, 1) share all stimulus and
// are checked every cycle against a write-address-indexed reference model.
module tb_feature_map_pingpong_buffer;

    localparam int LANES = 9;
    localparam int W     = 36;
    localparam int WW    = LANES * W;
    localparam int DW    = WW * 4;
    localparam int NWA   = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [WW-1:0]   wr_data;
    logic            wr_valid;
    logic [9:0]      wr_addr;
    logic            wr_last;
    logic            rd_req;
    logic [9:0]      rd_addr;
    logic            rd_last;

    logic            wr_ready_o [3];
    logic            rd_bank_ready_o [3];
    logic            rd_valid_o [3];
    logic            wr_bank_o [3];
    logic            rd_bank_o [3];
    logic            wr_err_o [3];
    logic            rd_err_o [3];
    logic [1:0]      full_count_o [3];
    logic [DW-1:0]   rd_data4;
    logic [DW/2-1:0] rd_data2;
    logic [WW-1:0]   rd_data1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    feature_map_pingpong_buffer #(.RATIO(4)) dut4 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_last(wr_last), .wr_ready(wr_ready_o[0]), .rd_req(rd_req), .rd_addr(rd_addr[7:0]),
        .rd_last(rd_last), .rd_bank_ready(rd_bank_ready_o[0]), .rd_data(rd_data4),
        .rd_valid(rd_valid_o[0]), .wr_bank(wr_bank_o[0]), .rd_bank(rd_bank_o[0]),
        .full_count(full_count_o[0]), .wr_err(wr_err_o[0]), .rd_err(rd_err_o[0]));

    feature_map_pingpong_buffer #(.RATIO(2)) dut2 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_last(wr_last), .wr_ready(wr_ready_o[1]), .rd_req(rd_req), .rd_addr(rd_addr[8:0]),
        .rd_last(rd_last), .rd_bank_ready(rd_bank_ready_o[1]), .rd_data(rd_data2),
        .rd_valid(rd_valid_o[1]), .wr_bank(wr_bank_o[1]), .rd_bank(rd_bank_o[1]),
        .full_count(full_count_o[1]), .wr_err(wr_err_o[1]), .rd_err(rd_err_o[1]));

    feature_map_pingpong_buffer #(.RATIO(1)) dut1 (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_last(wr_last), .wr_ready(wr_ready_o[2]), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_last(rd_last), .rd_bank_ready(rd_bank_ready_o[2]), .rd_data(rd_data1),
        .rd_valid(rd_valid_o[2]), .wr_bank(wr_bank_o[2]), .rd_bank(rd_bank_o[2]),
        .full_count(full_count_o[2]), .wr_err(wr_err_o[2]), .rd_err(rd_err_o[2]));

    function automatic int rat(input int n);
        return (n == 0) ? 4 : ((n == 1) ? 2 : 1);
    endfunction

    function automatic logic [DW-1:0] rd_of(input int n);
        if (n == 0) return rd_data4;
        if (n == 1) return DW'(rd_data2);
        return DW'(rd_data1);
    endfunction

    task automatic chk(input string nm, input int n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual %0h required %0h", nm, n, act, exp);
        end
    endtask

    task automatic chk_data(input string nm, input int n, input logic [DW-1:0] act,
                            input logic [DW-1:0] exp, input logic [DW-1:0] msk);
        logic [DW-1:0] diff;
        int c;
        checks++;
        diff = (act ^ exp) & msk;
        if (diff != '0) begin
            errors++;
            c = 0;
            while (diff[c*144 +: 144] == '0) c++;
            $display("FAIL %s dut%0d chunk %0d actual %h required %h", nm, n, c,
                     act[c*144 +: 144], exp[c*144 +: 144] & msk[c*144 +: 144]);
        end
    endtask

    // Reference model: bank occupancy as booleans, memory kept per written narrow address.
    bit            full [2];
    bit            fb, db, m_werr, m_rerr, m_valid, started;
    logic [DW-1:0] m_data [3];
    logic [DW-1:0] m_mask [3];
    logic [W-1:0]  md [2][LANES][NWA];
    bit            mk [2][LANES][NWA];

    always @(posedge clk) begin
        bit wr_ok, rd_ok;
        int r, a, p;
        if (rst) begin
            full[0] = 0; full[1] = 0; fb = 0; db = 0;
            m_werr = 0; m_rerr = 0; m_valid = 0; started = 1;
            for (int n = 0; n < 3; n++) begin
                m_data[n] = '0;
                m_mask[n] = '1;
            end
        end else if (started) begin
            wr_ok   = !full[fb];
            rd_ok   = full[db];
            m_valid = 0;
            if (rd_req) begin
                if (rd_ok) begin
                    m_valid = 1;
                    for (int n = 0; n < 3; n++) begin
                        r = rat(n);
                        a = int'(rd_addr) % (NWA / r);
                        m_data[n] = '0;
                        m_mask[n] = '0;
                        for (int i = 0; i < LANES; i++)
                            for (int k = 0; k < r; k++) begin
                                p = a * r + k;
                                m_data[n][(i*r + k)*W +: W] = md[db][i][p];
                                m_mask[n][(i*r + k)*W +: W] = {W{mk[db][i][p]}};
                            end
                    end
                    if (rd_last) begin
                        full[db] = 0;
                        db = !db;
                    end
                end else m_rerr = 1;
            end
            if (wr_valid) begin
                if (wr_ok) begin
                    for (int i = 0; i < LANES; i++) begin
                        md[fb][i][wr_addr] = wr_data[i*W +: W];
                        mk[fb][i][wr_addr] = 1;
                    end
                    if (wr_last) begin
                        full[fb] = 1;
                        fb = !fb;
                    end
                end else m_werr = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int n = 0; n < 3; n++) begin
                chk("wr_ready", n, 32'(wr_ready_o[n]), 32'(!full[fb]));
                chk("rd_bank_ready", n, 32'(rd_bank_ready_o[n]), 32'(full[db]));
                chk("full_count", n, 32'(full_count_o[n]), 32'(full[0]) + 32'(full[1]));
                chk("wr_bank", n, 32'(wr_bank_o[n]), 32'(fb));
                chk("rd_bank", n, 32'(rd_bank_o[n]), 32'(db));
                chk("wr_err", n, 32'(wr_err_o[n]), 32'(m_werr));
                chk("rd_err", n, 32'(rd_err_o[n]), 32'(m_rerr));
                chk("rd_valid", n, 32'(rd_valid_o[n]), 32'(m_valid));
                chk_data("rd_data", n, rd_of(n), m_data[n], m_mask[n]);
            end
        end
    end

    task automatic idle();
        wr_valid = 0; wr_last = 0; rd_req = 0; rd_last = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [9:0] a, input logic [W-1:0] d0, input bit last);
        wr_valid = 1; wr_addr = a; wr_last = last;
        for (int i = 0; i < LANES; i++) begin
            wr_data[i*W +: 32]    = $urandom;
            wr_data[i*W + 32 +: 4] = 4'($urandom);
        end
        wr_data[W-1:0] = d0;
    endtask

    task automatic rd(input logic [9:0] a, input bit last);
        rd_req = 1; rd_addr = a; rd_last = last;
    endtask

    // Writes addrs 0..3 with lane0 = base+1..base+4, committing on addr 3.
    task automatic fill(input logic [W-1:0] base);
        for (int k = 0; k < 4; k++) begin
            wr(10'(k), base + W'(k + 1), k == 3);
            step();
            idle();
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_wr_ready", 0, 32'(wr_ready_o[0]), 1);
        chk("rst_rd_bank_ready", 0, 32'(rd_bank_ready_o[0]), 0);
        chk("rst_full_count", 0, 32'(full_count_o[0]), 0);
        chk("rst_rd_valid", 0, 32'(rd_valid_o[0]), 0);
        chk("rst_wr_bank", 0, 32'(wr_bank_o[0]), 0);
        chk("rst_errs", 0, {30'd0, wr_err_o[0], rd_err_o[0]}, 0);
        chk_data("rst_rd_data", 0, rd_data4, '0, '1);
    endtask

    initial begin
        rst = 1; wr_addr = '0; rd_addr = '0; wr_data = '0;
        idle();
        repeat (3) step();
        rst = 0;
        chk_reset_state();

        // Narrow writes assembled into one wide word, viewed at each ratio.
        fill(36'h0);
        chk("t2_full_count", 0, 32'(full_count_o[0]), 1);
        chk("t2_wr_bank", 0, 32'(wr_bank_o[0]), 1);
        rd(10'd0, 0); step(); idle();
        chk("t2_rd_valid", 0, 32'(rd_valid_o[0]), 1);
        chk_data("t2_r4", 0, DW'(rd_data4[143:0]), DW'({36'h4, 36'h3, 36'h2, 36'h1}), '1);
        chk_data("t2_r2", 1, DW'(rd_data2[71:0]), DW'({36'h2, 36'h1}), '1);
        chk_data("t2_r1", 2, DW'(rd_data1[35:0]), DW'(36'h1), '1);
        rd(10'd1, 0); step(); idle();
        chk_data("t2_r2_a1", 1, DW'(rd_data2[71:0]), DW'({36'h4, 36'h3}), '1);
        chk_data("t2_r1_a1", 2, DW'(rd_data1[35:0]), DW'(36'h2), '1);

        // Both banks full: further write rejected, contents intact.
        fill(36'h10);
        chk("t3_full_count", 0, 32'(full_count_o[0]), 2);
        chk("t3_wr_ready", 0, 32'(wr_ready_o[0]), 0);
        wr(10'd0, 36'hfff, 0); step(); idle();
        chk("t3_wr_err", 0, 32'(wr_err_o[0]), 1);
        rd(10'd0, 1); step(); idle();
        chk_data("t3_bank0", 0, DW'(rd_data4[143:0]), DW'({36'h4, 36'h3, 36'h2, 36'h1}), '1);
        chk("t3_rd_bank", 0, 32'(rd_bank_o[0]), 1);
        rd(10'd0, 1); step(); idle();
        chk_data("t3_bank1", 0, DW'(rd_data4[143:0]), DW'({36'h14, 36'h13, 36'h12, 36'h11}), '1);
        chk("t3_full_empty", 0, 32'(full_count_o[0]), 0);

        // Release bank0 while committing bank1 in the same cycle.
        fill(36'h20);
        for (int k = 0; k < 3; k++) begin
            wr(10'(k), 36'h31 + W'(k), 0); step(); idle();
        end
        wr(10'd3, 36'h34, 1); rd(10'd0, 1); step(); idle();
        for (int n = 0; n < 3; n++) begin
            chk("t4_full_count", n, 32'(full_count_o[n]), 1);
            chk("t4_rd_bank", n, 32'(rd_bank_o[n]), 1);
            chk("t4_wr_bank", n, 32'(wr_bank_o[n]), 0);
        end
        chk_data("t4_bank0", 0, DW'(rd_data4[143:0]), DW'({36'h24, 36'h23, 36'h22, 36'h21}), '1);
        chk_data("t4_bank0_r1", 2, DW'(rd_data1[35:0]), DW'(36'h21), '1);
        rd(10'd0, 1); step(); idle();
        chk_data("t4_bank1", 0, DW'(rd_data4[143:0]), DW'({36'h34, 36'h33, 36'h32, 36'h31}), '1);
        chk_data("t4_bank1_r2", 1, DW'(rd_data2[71:0]), DW'({36'h32, 36'h31}), '1);

        // Reset mid-tile, then read with nothing full, then refill.
        wr(10'd0, 36'h41, 0); step(); wr(10'd1, 36'h42, 0); step(); idle();
        rst = 1; step(); rst = 0;
        chk_reset_state();
        chk("t6_rd_bank", 0, 32'(rd_bank_o[0]), 0);
        rd(10'd0, 0); step(); idle();
        chk("t5_rd_valid", 0, 32'(rd_valid_o[0]), 0);
        chk("t5_rd_err", 0, 32'(rd_err_o[0]), 1);
        repeat (3) step();
        chk("t5_rd_err_sticky", 0, 32'(rd_err_o[0]), 1);
        fill(36'h50);
        rd(10'd0, 1); step(); idle();
        chk_data("t6_refill", 0, DW'(rd_data4[143:0]), DW'({36'h54, 36'h53, 36'h52, 36'h51}), '1);

        // Randomized traffic over a small address window so reads hit written data.
        for (int c = 0; c < 1500; c++) begin
            wr(10'($urandom_range(0, 31)), 36'($urandom), $urandom_range(0, 9) == 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            rd(10'($urandom_range(0, 7)), $urandom_range(0, 7) == 0);
            rd_req = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        idle(); rst = 0;
        repeat (2) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
